// File: rtl/twiddle_server.sv
// FFT twiddle server: k -> (cos, -sin) from a quarter-wave ROM via quadrant symmetry.
// Response registered ROM_LAT+2 edges after accept; one request in flight, held until rsp_ready.
module twiddle_server #(
  parameter int ROM_LAT = 2,
  parameter int DW      = 16,
  parameter int LOG2_N  = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [LOG2_N-1:0]    req_k,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic signed [DW-1:0] rsp_re,
  output logic signed [DW-1:0] rsp_im,
  output logic [LOG2_N-2:0]    rom_ad,
  output logic                 rom_ce,
  output logic                 rom_oce,
  output logic                 rom_reset,
  input  logic [DW-1:0]        rom_dout
);

  localparam int AW = LOG2_N - 1;
  localparam int QW = LOG2_N - 2;
  localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [AW-1:0] Q_AD = AW'(1 << QW);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WAIT, OUT} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [1:0]           q_r;
  logic [QW-1:0]        r_r;
  logic [DW-1:0]        ta_r;
  logic [CW-1:0]        cnt;
  logic signed [DW-1:0] ta_s;
  logic signed [DW-1:0] tb_s;
  logic signed [DW-1:0] re_nxt;
  logic signed [DW-1:0] im_nxt;

  assign rom_ce    = 1'b1;
  assign rom_oce   = 1'b1;
  assign rom_reset = ~rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = RD_A;
      RD_A:    state_nxt = RD_B;
      RD_B:    if (cnt == '0) state_nxt = WAIT;
      WAIT:    state_nxt = OUT;
      OUT:     if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // TB arrives straight off the ROM in WAIT; TA was parked in ta_r one edge earlier.
  always_comb begin
    ta_s   = ta_r;
    tb_s   = rom_dout;
    re_nxt = ta_s;
    im_nxt = -tb_s;
    case (q_r)
      2'd0: begin re_nxt = ta_s;  im_nxt = -tb_s; end
      2'd1: begin re_nxt = -tb_s; im_nxt = -ta_s; end
      2'd2: begin re_nxt = -ta_s; im_nxt = tb_s;  end
      2'd3: begin re_nxt = tb_s;  im_nxt = ta_s;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_re    <= '0;
      rsp_im    <= '0;
      rom_ad    <= '0;
      q_r       <= '0;
      r_r       <= '0;
      ta_r      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            q_r       <= req_k[LOG2_N-1 -: 2];
            r_r       <= req_k[QW-1:0];
            rom_ad    <= {1'b0, req_k[QW-1:0]};
            req_ready <= 1'b0;
          end
        end
        RD_A: begin
          rom_ad <= Q_AD - {1'b0, r_r};
          cnt    <= CW'(ROM_LAT - 1);
        end
        RD_B: begin
          if (cnt == '0) ta_r <= rom_dout;
          else           cnt  <= cnt - 1'b1;
        end
        WAIT: begin
          rsp_re    <= re_nxt;
          rsp_im    <= im_nxt;
          rsp_valid <= 1'b1;
        end
        OUT: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_twiddle_server.sv
// Bench for twiddle_server: ROM model with 2-cycle latency, directed corners, backpressure, reset, full sweep.
module tb_twiddle_server;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic [11:0]        req_k;
  logic               rsp_valid;
  logic               rsp_ready;
  logic signed [15:0] rsp_re;
  logic signed [15:0] rsp_im;
  logic [10:0]        rom_ad;
  logic               rom_ce;
  logic               rom_oce;
  logic               rom_reset;
  logic [15:0]        rom_dout;

  int checks = 0;
  int errors = 0;
  int T[0:1024];

  twiddle_server #(.ROM_LAT(2), .DW(16), .LOG2_N(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_k(req_k),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_re(rsp_re), .rsp_im(rsp_im),
    .rom_ad(rom_ad), .rom_ce(rom_ce), .rom_oce(rom_oce),
    .rom_reset(rom_reset), .rom_dout(rom_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pROM: address sampled at edge Ea, data visible for capture at edge Ea+2
  logic [15:0] rom_d1, rom_d2;
  always @(posedge clk) begin
    if (rom_reset) begin
      rom_d1 <= '0;
      rom_d2 <= '0;
    end else begin
      if (rom_ce)  rom_d1 <= 16'(T[rom_ad]);
      if (rom_oce) rom_d2 <= rom_d1;
    end
  end
  assign rom_dout = rom_d2;

  // cos(2*pi*m/4096) scaled by 32767, folded onto the quarter table by angle
  function automatic int cos_m(int m);
    int mm;
    mm = ((m % 4096) + 4096) % 4096;
    if (mm <= 1024)      return T[mm];
    else if (mm <= 2048) return -T[2048 - mm];
    else if (mm <= 3072) return -T[mm - 2048];
    else                 return T[4096 - mm];
  endfunction

  function automatic int exp_re(int k);
    return cos_m(k);
  endfunction

  function automatic int exp_im(int k);
    return -cos_m(k - 1024);
  endfunction

  task automatic wait_ready(input string name);
    int g;
    g = 0;
    while (!req_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!req_ready) begin
      errors++;
      $display("FAIL %s: req_ready timeout got %0b expected 1", name, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_k = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_re !== 16'sd0 || rsp_im !== 16'sd0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%0b vld=%0b re=%0d im=%0d expected 1 0 0 0",
               req_ready, rsp_valid, rsp_re, rsp_im);
    end
    checks++;
    if (rom_ad !== 11'd0 || rom_ce !== 1'b1 || rom_oce !== 1'b1 || rom_reset !== 1'b1) begin
      errors++;
      $display("FAIL reset_rom: got ad=%0d ce=%0b oce=%0b rst=%0b expected 0 1 1 1",
               rom_ad, rom_ce, rom_oce, rom_reset);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (rom_reset !== 1'b0) begin
      errors++;
      $display("FAIL rom_reset_release: got %0b expected 0", rom_reset);
    end
  endtask

  // One request with address sequence, latency and result checked
  task automatic run_one(input int k, input int er, input int ei, input string name);
    int lat;
    int r;
    r = k % 1024;
    wait_ready(name);
    req_valid = 1'b1; req_k = 12'(k);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (rom_ad !== 11'(r)) begin
      errors++;
      $display("FAIL %s_addr_a: got %0d expected %0d", name, rom_ad, r);
    end
    @(posedge clk); #1;
    checks++;
    if (rom_ad !== 11'(1024 - r)) begin
      errors++;
      $display("FAIL %s_addr_b: got %0d expected %0d", name, rom_ad, 1024 - r);
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges expected 4", name, lat);
    end
    checks++;
    if (rsp_re !== 16'(er) || rsp_im !== 16'(ei)) begin
      errors++;
      $display("FAIL %s_value: got re=%0d im=%0d expected re=%0d im=%0d", name, rsp_re, rsp_im, er, ei);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handshake: got vld=%0b rdy=%0b expected 0 1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_corners();
    run_one(0,    32767,      0, "k0");
    run_one(1024,     0, -32767, "k1024");
    run_one(2048, -32767,     0, "k2048");
    run_one(3072,     0,  32767, "k3072");
    run_one(512,  23170, -23170, "k512");
    run_one(3584, 23170,  23170, "k3584");
    run_one(1536, -23170, -23170, "k1536");
  endtask

  task automatic test_backpressure();
    int g;
    wait_ready("bp");
    req_valid = 1'b1; req_k = 12'd512;
    @(posedge clk); #1;
    req_k = 12'd1636;
    g = 0;
    while (!rsp_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_re !== 16'sd23170 || rsp_im !== -16'sd23170 || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got vld=%0b re=%0d im=%0d rdy=%0b expected 1 23170 -23170 0",
                 i, rsp_valid, rsp_re, rsp_im, req_ready);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got vld=%0b rdy=%0b expected 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || rom_ad !== 11'd612) begin
      errors++;
      $display("FAIL bp_second_accept: got rdy=%0b ad=%0d expected 0 612", req_ready, rom_ad);
    end
    g = 0;
    while (!rsp_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_re !== 16'(exp_re(1636)) || rsp_im !== 16'(exp_im(1636))) begin
      errors++;
      $display("FAIL bp_second_value: got vld=%0b re=%0d im=%0d expected 1 %0d %0d",
               rsp_valid, rsp_re, rsp_im, exp_re(1636), exp_im(1636));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_midflight();
    wait_ready("rst_mid");
    req_valid = 1'b1; req_k = 12'd3000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rom_reset !== 1'b1 || rom_ad !== 11'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got vld=%0b rdy=%0b rst=%0b ad=%0d expected 0 1 1 0",
               rsp_valid, req_ready, rom_reset, rom_ad);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (5) begin
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_no_rsp: got vld=%0b expected 0", rsp_valid);
      end
      @(posedge clk); #1;
    end
    run_one(0, 32767, 0, "rst_mid_k0");
  endtask

  task automatic test_sweep();
    int exp_q[$];
    int got;
    fork
      begin
        bit acc;
        int g;
        for (int k = 0; k < 4096; k++) begin
          req_valid = 1'b1; req_k = 12'(k);
          acc = 1'b0; g = 0;
          while (!acc && g < 200) begin
            acc = req_ready;
            @(posedge clk); #1;
            g++;
          end
          if (acc) exp_q.push_back(k);
        end
        req_valid = 1'b0;
      end
      begin
        int cyc;
        int k;
        bit rdy;
        got = 0; cyc = 0;
        while (got < 4096 && cyc < 60000) begin
          rdy = 1'($urandom_range(0, 1));
          rsp_ready = rdy;
          if (rsp_valid && rdy) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL sweep_extra: got re=%0d im=%0d expected no response", rsp_re, rsp_im);
            end else begin
              k = exp_q.pop_front();
              if (rsp_re !== 16'(exp_re(k)) || rsp_im !== 16'(exp_im(k))) begin
                errors++;
                $display("FAIL sweep_k%0d: got re=%0d im=%0d expected re=%0d im=%0d",
                         k, rsp_re, rsp_im, exp_re(k), exp_im(k));
              end
            end
            got++;
          end
          @(posedge clk); #1;
          cyc++;
        end
        rsp_ready = 1'b0;
      end
    join
    checks++;
    if (got !== 4096 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL sweep_count: got %0d responses, %0d outstanding expected 4096, 0", got, exp_q.size());
    end
  endtask

  initial begin
    for (int a = 0; a <= 1024; a++)
      T[a] = int'(32767.0 * $cos(2.0 * 3.141592653589793 * real'(a) / 4096.0));
    test_reset();
    test_corners();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
